// File: rtl/param_datapath.sv
// Parametrised bus-based CPU datapath: GPRs, PC/IR/MAR/MDR/Y/HI/LO, 2W-bit Z, ALU and an iterative MUL/DIV unit.
// Optional macro FAST_MUL_EN turns MUL into a single-cycle ALU op; DIV always stays iterative.
module param_datapath #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       Mdatain,
  input  logic                   read,
  input  logic                   MDRin,
  input  logic [4:0]             bus_src,
  input  logic                   use_ir_sel,
  input  logic                   Gra,
  input  logic                   Grb,
  input  logic                   Grc,
  input  logic                   BAout,
  input  logic                   Rin,
  input  logic                   PCin,
  input  logic                   IRin,
  input  logic                   MARin,
  input  logic                   Yin,
  input  logic                   HIin,
  input  logic                   LOin,
  input  logic                   Zin,
  input  logic [3:0]             alu_op,
  input  logic                   alu_start,
  input  logic [3:0]             dbg_sel,
  output logic [WIDTH-1:0]       bus_mux_out,
  output logic [WIDTH-1:0]       IR,
  output logic [WIDTH-1:0]       MAR,
  output logic [WIDTH-1:0]       PC,
  output logic [2*WIDTH-1:0]     Z,
  output logic                   busy,
  output logic                   done,
  output logic                   div_by_zero,
  output logic [WIDTH-1:0]       dbg_data
);

  localparam int SHW  = $clog2(WIDTH);
  localparam int IDXW = $clog2(NUM_REGS);
  localparam int CW   = $clog2(WIDTH + 1);

`ifdef FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  logic [WIDTH-1:0] gpr [NUM_REGS];
  logic [WIDTH-1:0] mdr, y_reg, hi_reg, lo_reg;

  // register index: IR field (one-hot Gra/Grb/Grc) or the low bits of bus_src
  logic [3:0] ra, rb, rc, ir_idx, reg_idx;
  logic       idx_ok, dbg_ok;
  logic [WIDTH-1:0] gpr_rd, c_ext;

  assign ra      = IR[WIDTH-6:WIDTH-9];
  assign rb      = IR[WIDTH-10:WIDTH-13];
  assign rc      = IR[WIDTH-14:WIDTH-17];
  assign ir_idx  = ({4{Gra}} & ra) | ({4{Grb}} & rb) | ({4{Grc}} & rc);
  assign reg_idx = use_ir_sel ? ir_idx : bus_src[3:0];
  assign idx_ok  = ({1'b0, reg_idx} < 5'(NUM_REGS));
  assign dbg_ok  = ({1'b0, dbg_sel} < 5'(NUM_REGS));
  assign c_ext   = {{17{IR[WIDTH-18]}}, IR[WIDTH-18:0]};

  always_comb begin
    gpr_rd = '0;
    if (idx_ok && !(BAout && reg_idx == 4'd0))
      gpr_rd = gpr[reg_idx[IDXW-1:0]];
  end

  always_comb begin
    dbg_data = '0;
    if (dbg_ok)
      dbg_data = gpr[dbg_sel[IDXW-1:0]];
  end

  always_comb begin
    bus_mux_out = '0;
    case (bus_src)
      5'd16:   bus_mux_out = hi_reg;
      5'd17:   bus_mux_out = lo_reg;
      5'd18:   bus_mux_out = Z[2*WIDTH-1:WIDTH];
      5'd19:   bus_mux_out = Z[WIDTH-1:0];
      5'd20:   bus_mux_out = PC;
      5'd21:   bus_mux_out = mdr;
      5'd23:   bus_mux_out = c_ext;
      default: if (!bus_src[4]) bus_mux_out = gpr_rd;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < NUM_REGS; i++) gpr[i] <= '0;
    end else if (Rin && idx_ok) begin
      gpr[reg_idx[IDXW-1:0]] <= bus_mux_out;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      PC <= '0; IR <= '0; MAR <= '0; mdr <= '0;
      y_reg <= '0; hi_reg <= '0; lo_reg <= '0;
    end else begin
      if (PCin)  PC     <= bus_mux_out;
      if (IRin)  IR     <= bus_mux_out;
      if (MARin) MAR    <= bus_mux_out;
      if (Yin)   y_reg  <= bus_mux_out;
      if (HIin)  hi_reg <= bus_mux_out;
      if (LOin)  lo_reg <= bus_mux_out;
      if (MDRin) mdr    <= read ? Mdatain : bus_mux_out;
    end
  end

  // single-cycle ALU: A = Y, B = bus; unary ops act on B
  logic [SHW-1:0]     sh;
  int                 rot_amt;
  logic [WIDTH-1:0]   alu_lo;
  logic [2*WIDTH-1:0] alu_res;

  assign sh = bus_mux_out[SHW-1:0];

  always_comb begin
    rot_amt = int'(sh) % WIDTH;
    alu_lo  = '0;
    case (alu_op)
      4'd0:  alu_lo = y_reg & bus_mux_out;
      4'd1:  alu_lo = y_reg | bus_mux_out;
      4'd2:  alu_lo = y_reg + bus_mux_out;
      4'd3:  alu_lo = y_reg - bus_mux_out;
      4'd6:  alu_lo = y_reg >> sh;
      4'd7:  alu_lo = y_reg << sh;
      4'd8:  alu_lo = (y_reg >> rot_amt) | (y_reg << (WIDTH - rot_amt));
      4'd9:  alu_lo = (y_reg << rot_amt) | (y_reg >> (WIDTH - rot_amt));
      4'd10: alu_lo = -bus_mux_out;
      4'd11: alu_lo = ~bus_mux_out;
      4'd12: alu_lo = bus_mux_out + 1'b1;
      default: alu_lo = '0;
    endcase
    alu_res = {{WIDTH{1'b0}}, alu_lo};
`ifdef FAST_MUL_EN
    if (alu_op == 4'd4)
      alu_res = $signed({{WIDTH{y_reg[WIDTH-1]}}, y_reg}) *
                $signed({{WIDTH{bus_mux_out[WIDTH-1]}}, bus_mux_out});
`endif
  end

  // iterative MUL/DIV on operand magnitudes; it_m is multiplicand or divisor
  logic               it_div, a_neg, b_neg, b_zero, start_ok;
  logic [WIDTH-1:0]   it_m, it_hi, it_lo, y_mag, b_mag;
  logic [CW-1:0]      it_cnt;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod, fix_z;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign start_ok = alu_start && !busy &&
                    (alu_op == 4'd5 || (!FAST_MUL && alu_op == 4'd4));
  assign y_mag    = y_reg[WIDTH-1] ? -y_reg : y_reg;
  assign b_mag    = bus_mux_out[WIDTH-1] ? -bus_mux_out : bus_mux_out;

  assign mul_sum   = {1'b0, it_hi} + (it_lo[0] ? {1'b0, it_m} : {(WIDTH+1){1'b0}});
  assign div_shift = {it_hi, it_lo[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, it_m};

  assign prod    = {it_hi, it_lo};
  assign quo_fix = b_zero ? '1 : ((a_neg ^ b_neg) ? -it_lo : it_lo);
  assign rem_fix = a_neg ? -it_hi : it_hi;
  assign fix_z   = it_div ? {rem_fix, quo_fix} : ((a_neg ^ b_neg) ? -prod : prod);

  // the last busy edge (count == WIDTH) applies the sign fix-up and writes Z
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      busy <= 1'b0; done <= 1'b0; div_by_zero <= 1'b0; Z <= '0;
      it_div <= 1'b0; a_neg <= 1'b0; b_neg <= 1'b0; b_zero <= 1'b0;
      it_m <= '0; it_hi <= '0; it_lo <= '0; it_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        if (it_cnt == CW'(WIDTH)) begin
          Z    <= fix_z;
          busy <= 1'b0;
          done <= 1'b1;
          if (it_div && b_zero) div_by_zero <= 1'b1;
        end else begin
          it_cnt <= it_cnt + 1'b1;
          if (it_div) begin
            if (div_diff[WIDTH+1]) begin
              it_hi <= div_shift[WIDTH-1:0];
              it_lo <= {it_lo[WIDTH-2:0], 1'b0};
            end else begin
              it_hi <= div_diff[WIDTH-1:0];
              it_lo <= {it_lo[WIDTH-2:0], 1'b1};
            end
          end else begin
            {it_hi, it_lo} <= {mul_sum, it_lo[WIDTH-1:1]};
          end
        end
      end else begin
        if (Zin) Z <= alu_res;
        if (start_ok) begin
          busy        <= 1'b1;
          div_by_zero <= 1'b0;
          it_cnt      <= '0;
          it_div      <= (alu_op == 4'd5);
          a_neg       <= y_reg[WIDTH-1];
          b_neg       <= bus_mux_out[WIDTH-1];
          b_zero      <= (bus_mux_out == '0);
          it_hi       <= '0;
          it_m        <= (alu_op == 4'd5) ? b_mag : y_mag;
          it_lo       <= (alu_op == 4'd5) ? y_mag : b_mag;
        end
      end
    end
  end

endmodule

// File: tb/tb_param_datapath.sv
// Directed, table-driven self-checking bench for param_datapath at WIDTH=32, NUM_REGS=16.
module tb_param_datapath;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           clear;
  logic [W-1:0]   Mdatain;
  logic           read, MDRin, use_ir_sel, Gra, Grb, Grc, BAout, Rin;
  logic           PCin, IRin, MARin, Yin, HIin, LOin, Zin, alu_start;
  logic [4:0]     bus_src;
  logic [3:0]     alu_op, dbg_sel;
  logic [W-1:0]   bus_mux_out, IR, MAR, PC, dbg_data;
  logic [2*W-1:0] Z;
  logic           busy, done, div_by_zero;

  int compared = 0;
  int mismatched = 0;

  param_datapath #(.WIDTH(W), .NUM_REGS(16)) dut (
    .clk(clk), .clear(clear), .Mdatain(Mdatain), .read(read), .MDRin(MDRin),
    .bus_src(bus_src), .use_ir_sel(use_ir_sel), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .BAout(BAout), .Rin(Rin), .PCin(PCin), .IRin(IRin), .MARin(MARin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .Zin(Zin), .alu_op(alu_op), .alu_start(alu_start),
    .dbg_sel(dbg_sel), .bus_mux_out(bus_mux_out), .IR(IR), .MAR(MAR), .PC(PC),
    .Z(Z), .busy(busy), .done(done), .div_by_zero(div_by_zero), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] y;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic [2*W-1:0] z;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(string n, logic [W-1:0] y, logic [W-1:0] b,
                              logic [3:0] op, logic [2*W-1:0] z);
    vec_t v;
    v.name = n; v.y = y; v.b = b; v.op = op; v.z = z;
    return v;
  endfunction

  task automatic checkOutput(string name, logic [2*W-1:0] act, logic [2*W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    read = 0; MDRin = 0; use_ir_sel = 0; Gra = 0; Grb = 0; Grc = 0; BAout = 0;
    Rin = 0; PCin = 0; IRin = 0; MARin = 0; Yin = 0; HIin = 0; LOin = 0;
    Zin = 0; alu_start = 0; bus_src = 5'd0; alu_op = 4'd0; Mdatain = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mdr(logic [W-1:0] v);
    Mdatain = v; read = 1; MDRin = 1;
    tick(); idle();
  endtask

  task automatic set_y(logic [W-1:0] v);
    load_mdr(v);
    bus_src = 5'd21; Yin = 1;
    tick(); idle();
  endtask

  // one single-cycle ALU operation: Y preloaded, operand B via MDR, result to Z
  task automatic applyStimulus(vec_t v);
    set_y(v.y);
    load_mdr(v.b);
    bus_src = 5'd21; alu_op = v.op; Zin = 1;
    tick(); idle();
  endtask

  // launch MUL/DIV and count edges until done; optional collision pulse mid-run
  task automatic run_iter(string name, logic [3:0] op, logic [W-1:0] y, logic [W-1:0] b,
                          logic [2*W-1:0] exp_z, logic exp_dbz, bit collide);
    logic [2*W-1:0] zb;
    int n;
    bit bad;
    set_y(y);
    load_mdr(b);
    zb = Z;
    bus_src = 5'd21; alu_op = op; alu_start = 1;
    tick(); idle();
    n = 0; bad = 0;
    while (done !== 1'b1 && n < 200) begin
      if (busy !== 1'b1 || Z !== zb) bad = 1;
      if (collide && n == 5) begin
        bus_src = 5'd21; alu_op = op; alu_start = 1; Zin = 1; Yin = 1;
      end
      tick(); idle();
      n++;
    end
    checkOutput({name, " latency"}, 64'(n), 64'(W + 1));
    checkOutput({name, " busy held, Z stable"}, 64'(bad), 64'd0);
    checkOutput({name, " busy low at done"}, 64'(busy), 64'd0);
    checkOutput({name, " Z"}, Z, exp_z);
    checkOutput({name, " div_by_zero"}, 64'(div_by_zero), 64'(exp_dbz));
    tick();
    checkOutput({name, " done one cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ir1;
    bit saw_done;

    vecs[0]  = mk("ADD overflow", 32'h7FFFFFFF, 32'h1,        4'd2,  64'h0000000080000000);
    vecs[1]  = mk("SHL by 4",     32'h12345678, 32'h24,       4'd7,  64'h23456780);
    vecs[2]  = mk("AND",          32'hF0F0F0F0, 32'h0FF00FF0, 4'd0,  64'h00F000F0);
    vecs[3]  = mk("OR",           32'hF0F0F0F0, 32'h0F0F0000, 4'd1,  64'hFFFFF0F0);
    vecs[4]  = mk("SUB negative", 32'h5,        32'h7,        4'd3,  64'hFFFFFFFE);
    vecs[5]  = mk("SHR logical",  32'h80000000, 32'h1F,       4'd6,  64'h1);
    vecs[6]  = mk("ROR 1",        32'h1,        32'h1,        4'd8,  64'h80000000);
    vecs[7]  = mk("ROL 4",        32'h80000001, 32'h4,        4'd9,  64'h18);
    vecs[8]  = mk("NEG",          32'h55,       32'h1,        4'd10, 64'hFFFFFFFF);
    vecs[9]  = mk("NOT",          32'h55,       32'h0000FFFF, 4'd11, 64'hFFFF0000);
    vecs[10] = mk("INCPC wrap",   32'h55,       32'hFFFFFFFF, 4'd12, 64'h0);
    vecs[11] = mk("op 13 zero",   32'h1234,     32'h5678,     4'd13, 64'h0);
    vecs[12] = mk("SUB min",      32'h0,        32'h80000000, 4'd3,  64'h80000000);

    idle();
    dbg_sel = 4'd0;
    clear = 1;
    #1;
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset Z", Z, 64'd0);
    checkOutput("reset PC", 64'(PC), 64'd0);
    #11 clear = 0;

    // register moves and IR-field selection
    load_mdr(32'h100);
    bus_src = 5'd21; PCin = 1; MARin = 1;
    tick(); idle();
    checkOutput("PC load", 64'(PC), 64'h100);
    checkOutput("MAR load", 64'(MAR), 64'h100);

    ir1 = (32'd3 << 23) | (32'd5 << 19) | (32'd7 << 15) | 32'h4001;
    load_mdr(ir1);
    bus_src = 5'd21; IRin = 1;
    tick(); idle();
    checkOutput("IR load", 64'(IR), 64'(ir1));
    load_mdr(32'h1234);
    bus_src = 5'd21; use_ir_sel = 1; Gra = 1; Rin = 1;
    tick(); idle();
    dbg_sel = 4'd3; #1;
    checkOutput("GPR3 via Gra", 64'(dbg_data), 64'h1234);
    bus_src = 5'd23; #1;
    checkOutput("C sign-extended", 64'(bus_mux_out), 64'hFFFFC001);
    bus_src = 5'd0; use_ir_sel = 1; Grb = 1; #1;
    checkOutput("bus GPR5 via Grb", 64'(bus_mux_out), 64'h0);
    idle();

    load_mdr(32'h0);
    bus_src = 5'd21; IRin = 1;
    tick(); idle();
    load_mdr(32'hBEEF);
    bus_src = 5'd21; use_ir_sel = 1; Gra = 1; Rin = 1;
    tick(); idle();
    dbg_sel = 4'd0; #1;
    checkOutput("GPR0 writable", 64'(dbg_data), 64'hBEEF);
    bus_src = 5'd0; use_ir_sel = 1; Grb = 1; BAout = 1; #1;
    checkOutput("BAout GPR0 zero", 64'(bus_mux_out), 64'h0);
    BAout = 0; #1;
    checkOutput("GPR0 on bus", 64'(bus_mux_out), 64'hBEEF);
    idle();
    bus_src = 5'd3; #1;
    checkOutput("bus GPR3 direct", 64'(bus_mux_out), 64'h1234);
    idle();

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i].name, Z, vecs[i].z);
      checkOutput({vecs[i].name, " busy"}, 64'(busy), 64'd0);
    end

    // non-MUL/DIV start is ignored
    bus_src = 5'd21; alu_op = 4'd2; alu_start = 1;
    tick(); idle();
    checkOutput("ADD start ignored", 64'(busy), 64'd0);

`ifdef FAST_MUL_EN
    set_y(32'd6);
    load_mdr(32'd7);
    bus_src = 5'd21; alu_op = 4'd4; Zin = 1; alu_start = 1;
    tick(); idle();
    checkOutput("fast MUL Z", Z, 64'd42);
    checkOutput("fast MUL busy", 64'(busy), 64'd0);
    tick();
    checkOutput("fast MUL no done", 64'(done), 64'd0);
`else
    run_iter("MUL -3x7", 4'd4, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFFFFFFFFEB, 1'b0, 1'b1);
    run_iter("MUL min x -1", 4'd4, 32'h80000000, 32'hFFFFFFFF, 64'h0000000080000000, 1'b0, 1'b0);
`endif
    run_iter("DIV -17/5", 4'd5, 32'hFFFFFFEF, 32'd5, 64'hFFFFFFFE_FFFFFFFD, 1'b0, 1'b1);
    run_iter("DIV 9/0", 4'd5, 32'd9, 32'd0, 64'h00000009_FFFFFFFF, 1'b1, 1'b0);
    run_iter("DIV 100/-7", 4'd5, 32'd100, 32'hFFFFFFF9, 64'h00000002_FFFFFFF2, 1'b0, 1'b0);

    // clear in the middle of a DIV with Z nonzero
    set_y(32'd50);
    load_mdr(32'd3);
    bus_src = 5'd21; alu_op = 4'd5; alu_start = 1;
    tick(); idle();
    repeat (10) tick();
    checkOutput("busy before abort", 64'(busy), 64'd1);
    #2 clear = 1;
    #1;
    checkOutput("abort busy", 64'(busy), 64'd0);
    checkOutput("abort done", 64'(done), 64'd0);
    checkOutput("abort Z", Z, 64'd0);
    checkOutput("abort PC", 64'(PC), 64'd0);
    checkOutput("abort div_by_zero", 64'(div_by_zero), 64'd0);
    for (int i = 0; i < 16; i++) begin
      dbg_sel = 4'(i); #1;
      checkOutput($sformatf("abort GPR%0d", i), 64'(dbg_data), 64'd0);
    end
    #1 clear = 0;
    saw_done = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) saw_done = 1;
    end
    checkOutput("no done after abort", 64'(saw_done), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
